julia_pixel_scheduler: RTL and testbench

Frame-level scheduler that shares a pool of N_WORKERS Julia-set iteration engines across one frame. Walks the screen in raster order, computes each pixel's fixed-point start coordinate, and loads free workers. Collects the per-pixel colour each worker produces and serialises the results onto one valid/ready pixel stream toward the frame-buffer writer. Sits between the frame control/parameter registers and the worker array.

---
 rtl/julia_pkg.sv | 11 +
 rtl/julia_rr_arbiter.sv | 52 +++++
 rtl/julia_pixel_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_julia_pixel_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// rtl/julia_pkg.sv - shared types and constants for the Julia frame scheduler and workers
package julia_pkg;
    localparam int COORD_W = 32;
    localparam int COLOR_W = 16;
    // Escape radius squared (4.0) in Q4.28, and the iteration cap used by the workers
    localparam logic [COORD_W-1:0] E_LIMIT = 32'h4000_0000;
    localparam int ITE_MAX = 255;

    typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN} frame_state_t;
    typedef enum logic [1:0] {S_FREE, S_LOAD, S_RUN, S_DONE} slot_state_t;
endpackage

// File: rtl/julia_rr_arbiter.sv
// rtl/julia_rr_arbiter.sv - N-way round-robin arbiter whose grant is frozen while the consumer stalls
module julia_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic             hold_i,
    input  logic             adv_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             rr_valid;
    logic [IDX_W-1:0] rr_idx;
    int               idx;

    always_comb begin
        rr_valid = 1'b0;
        rr_idx   = '0;
        idx      = 0;
        // Scan downward so the requester closest to the pointer is the last written
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % N;
            if (req_i[idx]) begin
                rr_valid = 1'b1;
                rr_idx   = IDX_W'(idx);
            end
        end
        gnt_valid_o = lock_q | rr_valid;
        gnt_idx_o   = lock_q ? lock_idx_q : rr_idx;
        ptr_d       = ptr_q;
        if (adv_i) begin
            ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= hold_i;
            lock_idx_q <= gnt_idx_o;
        end
    end
endmodule

// File: rtl/julia_pixel_scheduler.sv
// rtl/julia_pixel_scheduler.sv - raster dispatch of pixels to a worker pool and result serialisation
module julia_pixel_scheduler
    import julia_pkg::*;
#(
    parameter int N_WORKERS = 4,
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int ADDR_W    = 17
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [COORD_W-1:0]             x_start,
    input  logic [COORD_W-1:0]             y_start,
    input  logic [COORD_W-1:0]             dx,
    input  logic [COORD_W-1:0]             dy,
    input  logic [COORD_W-1:0]             cr,
    input  logic [COORD_W-1:0]             ci,
    output logic                           busy,
    output logic                           frame_done,
    output logic [N_WORKERS-1:0]           w_enable,
    output logic [COORD_W*N_WORKERS-1:0]   w_x0,
    output logic [COORD_W*N_WORKERS-1:0]   w_y0,
    output logic [COORD_W-1:0]             w_cr,
    output logic [COORD_W-1:0]             w_ci,
    input  logic [N_WORKERS-1:0]           w_calc_end,
    input  logic [COLOR_W*N_WORKERS-1:0]   w_color,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [ADDR_W-1:0]              pix_addr,
    output logic [COLOR_W-1:0]             pix_color
);
    localparam int IDX_W = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(H_RES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    frame_state_t        frame_q;
    logic [COL_W-1:0]    col_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [COORD_W-1:0]  cur_x_q, cur_y_q, x_start_q, dx_q, dy_q, cr_q, ci_q;
    logic                frame_done_q;
    slot_state_t         slot_st_q [N_WORKERS];
    slot_state_t         slot_st_d [N_WORKERS];
    logic [COORD_W-1:0]  slot_x_q  [N_WORKERS];
    logic [COORD_W-1:0]  slot_y_q  [N_WORKERS];
    logic [ADDR_W-1:0]   slot_addr_q [N_WORKERS];

    logic                disp_free, dispatch, all_free_d, hs, gnt_valid;
    logic [IDX_W-1:0]    disp_idx, gnt_idx;
    logic [COL_W-1:0]    src_col, nxt_col;
    logic [ADDR_W-1:0]   src_addr;
    logic [COORD_W-1:0]  src_x, src_y, src_xs, src_dx, src_dy, nxt_x, nxt_y;
    logic [N_WORKERS-1:0] done_req;

    always_comb begin
        disp_free = 1'b0;
        disp_idx  = '0;
        for (int i = N_WORKERS - 1; i >= 0; i--) begin
            if (slot_st_q[i] == S_FREE) begin
                disp_free = 1'b1;
                disp_idx  = IDX_W'(i);
            end
        end
        // An accepted start dispatches pixel 0 on the same edge, straight from the inputs
        src_col  = col_q;
        src_addr = addr_q;
        src_x    = cur_x_q;
        src_y    = cur_y_q;
        src_xs   = x_start_q;
        src_dx   = dx_q;
        src_dy   = dy_q;
        if (frame_q == F_IDLE) begin
            src_col  = '0;
            src_addr = '0;
            src_x    = x_start;
            src_y    = y_start;
            src_xs   = x_start;
            src_dx   = dx;
            src_dy   = dy;
        end
        dispatch = disp_free && ((frame_q == F_IDLE && start) || frame_q == F_RUN);
        if (src_col == LAST_COL) begin
            nxt_col = '0;
            nxt_x   = src_xs;
            nxt_y   = src_y + src_dy;
        end else begin
            nxt_col = src_col + 1'b1;
            nxt_x   = src_x + src_dx;
            nxt_y   = src_y;
        end
    end

    always_comb begin
        hs         = pix_valid && pix_ready;
        all_free_d = 1'b1;
        done_req   = '0;
        for (int i = 0; i < N_WORKERS; i++) begin
            slot_st_d[i] = slot_st_q[i];
            done_req[i]  = (slot_st_q[i] == S_DONE);
            case (slot_st_q[i])
                S_FREE: if (dispatch && disp_idx == IDX_W'(i)) slot_st_d[i] = S_LOAD;
                S_LOAD: slot_st_d[i] = S_RUN;
                S_RUN:  if (w_calc_end[i]) slot_st_d[i] = S_DONE;
                S_DONE: if (hs && gnt_idx == IDX_W'(i)) slot_st_d[i] = S_FREE;
                default: slot_st_d[i] = S_FREE;
            endcase
            if (slot_st_d[i] != S_FREE) all_free_d = 1'b0;
        end
    end

    julia_rr_arbiter #(.N(N_WORKERS), .IDX_W(IDX_W)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (done_req),
        .hold_i      (pix_valid && !pix_ready),
        .adv_i       (hs),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q      <= F_IDLE;
            col_q        <= '0;
            addr_q       <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            x_start_q    <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            cr_q         <= '0;
            ci_q         <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < N_WORKERS; i++) begin
                slot_st_q[i]   <= S_FREE;
                slot_x_q[i]    <= '0;
                slot_y_q[i]    <= '0;
                slot_addr_q[i] <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            for (int i = 0; i < N_WORKERS; i++) slot_st_q[i] <= slot_st_d[i];
            if (dispatch) begin
                slot_x_q[disp_idx]    <= src_x;
                slot_y_q[disp_idx]    <= src_y;
                slot_addr_q[disp_idx] <= src_addr;
                col_q   <= nxt_col;
                addr_q  <= src_addr + 1'b1;
                cur_x_q <= nxt_x;
                cur_y_q <= nxt_y;
            end
            case (frame_q)
                F_IDLE: if (start) begin
                    x_start_q <= x_start;
                    dx_q      <= dx;
                    dy_q      <= dy;
                    cr_q      <= cr;
                    ci_q      <= ci;
                    frame_q   <= (src_addr == LAST_ADDR) ? F_DRAIN : F_RUN;
                end
                F_RUN: if (dispatch && src_addr == LAST_ADDR) frame_q <= F_DRAIN;
                F_DRAIN: if (all_free_d) begin
                    frame_done_q <= 1'b1;
                    frame_q      <= F_IDLE;
                end
                default: frame_q <= F_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (frame_q != F_IDLE);
        frame_done = frame_done_q;
        w_cr       = cr_q;
        w_ci       = ci_q;
        w_x0       = '0;
        w_y0       = '0;
        w_enable   = '0;
        for (int i = 0; i < N_WORKERS; i++) begin
            w_enable[i]                   = (slot_st_q[i] == S_RUN) || (slot_st_q[i] == S_DONE);
            w_x0[i*COORD_W +: COORD_W]    = slot_x_q[i];
            w_y0[i*COORD_W +: COORD_W]    = slot_y_q[i];
        end
        pix_valid = gnt_valid;
        pix_addr  = gnt_valid ? slot_addr_q[gnt_idx] : '0;
        pix_color = gnt_valid ? w_color[int'(gnt_idx)*COLOR_W +: COLOR_W] : '0;
    end
endmodule

// File: tb/tb_julia_pixel_scheduler.sv
// tb/tb_julia_pixel_scheduler.sv - self-checking bench for julia_pixel_scheduler
module tb_julia_pixel_scheduler;
    localparam int NW = 2, H = 4, V = 2, AW = 3, TOT = H * V;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_ready = 1'b1;
    logic [31:0] x_start = '0, y_start = '0, dx = '0, dy = '0, cr = '0, ci = '0;
    logic busy, frame_done, pix_valid;
    logic [NW-1:0] w_enable;
    logic [NW-1:0] w_calc_end = '0;
    logic [32*NW-1:0] w_x0, w_y0;
    logic [31:0] w_cr, w_ci;
    logic [16*NW-1:0] w_color;
    logic [AW-1:0] pix_addr;
    logic [15:0] pix_color;

    always #5 clk = ~clk;

    julia_pixel_scheduler #(.N_WORKERS(NW), .H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_start(x_start), .y_start(y_start), .dx(dx), .dy(dy), .cr(cr), .ci(ci),
        .busy(busy), .frame_done(frame_done),
        .w_enable(w_enable), .w_x0(w_x0), .w_y0(w_y0), .w_cr(w_cr), .w_ci(w_ci),
        .w_calc_end(w_calc_end), .w_color(w_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_color(pix_color)
    );

    int n_vec = 0, n_err = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Frame model: pixel a sits at column a%H, row a/H
    logic [31:0] m_xs, m_ys, m_dx, m_dy;
    function automatic logic [31:0] mx(input int a);
        return m_xs + 32'(a % H) * m_dx;
    endfunction
    function automatic logic [31:0] my(input int a);
        return m_ys + 32'(a / H) * m_dy;
    endfunction
    function automatic logic [15:0] hue(input logic [31:0] x, input logic [31:0] y);
        return x[31:16] ^ y[23:8] ^ x[15:0];
    endfunction

    // Worker models: latch start point while disabled, report after lat[i] enabled cycles
    int lat [NW];
    int wcnt [NW];
    logic [31:0] wx [NW];
    logic [31:0] wy [NW];
    always @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (!w_enable[i]) begin
                wcnt[i]       <= 0;
                w_calc_end[i] <= 1'b0;
                wx[i]         <= w_x0[i*32 +: 32];
                wy[i]         <= w_y0[i*32 +: 32];
            end else begin
                if (wcnt[i] < lat[i]) wcnt[i] <= wcnt[i] + 1;
                if (wcnt[i] + 1 >= lat[i]) w_calc_end[i] <= 1'b1;
            end
        end
    end
    always_comb begin
        w_color = '0;
        for (int i = 0; i < NW; i++)
            w_color[i*16 +: 16] = w_calc_end[i] ? hue(wx[i], wy[i]) : 16'h0;
    end

    logic [AW-1:0] emit_q [$];
    logic [31:0] load_x [$];
    logic [31:0] load_y [$];
    bit seen [TOT];
    logic [15:0] out_col [TOT];
    int fd_cnt = 0, kk;
    bit mon_on = 0, prev_stall = 0;
    logic [AW-1:0] prev_addr;
    logic [15:0] prev_col;
    logic [NW-1:0] prev_en = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
            prev_en    = '0;
        end else if (mon_on) begin
            for (int i = 0; i < NW; i++) begin
                if (!prev_en[i] && w_enable[i]) begin
                    kk = load_x.size();
                    load_x.push_back(w_x0[i*32 +: 32]);
                    load_y.push_back(w_y0[i*32 +: 32]);
                    chk("load_x0", w_x0[i*32 +: 32], mx(kk));
                    chk("load_y0", w_y0[i*32 +: 32], my(kk));
                end
            end
            if (prev_stall) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_addr", pix_addr, prev_addr);
                chk("stall_color", pix_color, prev_col);
            end
            if (pix_valid && pix_ready) begin
                chk("dup_addr", seen[pix_addr], 0);
                seen[pix_addr] = 1;
                out_col[pix_addr] = pix_color;
                chk("pix_color", pix_color, hue(mx(int'(pix_addr)), my(int'(pix_addr))));
                emit_q.push_back(pix_addr);
            end
            if (frame_done) fd_cnt++;
            prev_stall = pix_valid && !pix_ready;
            prev_addr  = pix_addr;
            prev_col   = pix_color;
            prev_en    = w_enable;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] xs, ys, ddx, ddy);
        m_xs = xs; m_ys = ys; m_dx = ddx; m_dy = ddy;
        emit_q.delete(); load_x.delete(); load_y.delete();
        fd_cnt = 0;
        foreach (seen[a]) seen[a] = 0;
        @(posedge clk); #1;
        x_start = xs; y_start = ys; dx = ddx; dy = ddy; cr = 32'h0000_1234; ci = 32'hFFFF_8000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x_start = $urandom; y_start = $urandom; dx = $urandom; dy = $urandom; cr = $urandom;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (frame_done !== 1'b1 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_timeout"}, c < 500, 1);
        chk({name, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_frame(input string name);
        chk({name, "_emitted"}, emit_q.size(), TOT);
        chk({name, "_loads"}, load_x.size(), TOT);
        chk({name, "_done_pulses"}, fd_cnt, 1);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        lat[0] = 3; lat[1] = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_w_enable", w_enable, 0);
        chk("rst_w_x0", w_x0, 0);
        chk("rst_w_y0", w_y0, 0);
        chk("rst_w_cr_ci", {w_cr, w_ci}, 0);
        chk("rst_pix", {pix_valid, pix_addr, pix_color}, 0);
        rst = 1'b0;
        mon_on = 1;

        // Frame A: equal latency, always ready; pins coordinates of pixel 5
        m_xs = 32'hE000_0000; m_ys = 0; m_dx = 32'h0100_0000; m_dy = 32'h0080_0000;
        chk("model_x5", mx(5), 32'hE100_0000);
        chk("model_y5", my(5), 32'h0080_0000);
        chk("model_hue5", hue(mx(5), my(5)), 16'h6100);
        start_frame(32'hE000_0000, 32'h0, 32'h0100_0000, 32'h0080_0000);
        chk("t1_busy", busy, 1);
        chk("t1_w_enable", w_enable, 2'b00);
        chk("t1_slot0_x0", w_x0[31:0], 32'hE000_0000);
        @(posedge clk); #1;
        chk("t2_w_enable", w_enable, 2'b01);
        chk("t2_slot1_x0", w_x0[63:32], 32'hE100_0000);
        @(posedge clk); #1;
        chk("t3_w_enable", w_enable, 2'b11);
        wait_done("frameA");
        check_frame("frameA");
        chk("frameA_load5_x", load_x[5], 32'hE100_0000);
        chk("frameA_load5_y", load_y[5], 32'h0080_0000);
        chk("frameA_color5", out_col[5], 16'h6100);
        chk("frameA_cr_latched", w_cr, 32'h0000_1234);
        chk("frameA_ci_latched", w_ci, 32'hFFFF_8000);

        // Frame B: worker 1 much faster, so its pixel (addr 1) leaves first
        lat[0] = 12; lat[1] = 2;
        start_frame(32'h0010_0000, 32'h0200_0000, 32'h0003_0000, 32'hFF00_0000);
        wait_done("frameB");
        check_frame("frameB");
        chk("frameB_first_emit", emit_q[0], 1);

        // Frame C: sink stalled with both slots done, then released
        do_reset();
        lat[0] = 3; lat[1] = 3;
        pix_ready = 1'b0;
        start_frame(32'h1000_0000, 32'h2000_0000, 32'h0001_0000, 32'h0000_0100);
        c = 0;
        while (!(pix_valid && w_calc_end == 2'b11) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("stall_reach_timeout", c < 100, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_enables", w_enable, 2'b11);
            chk("stall_pix_valid", pix_valid, 1);
            @(posedge clk); #1;
        end
        chk("stall_nothing_out", emit_q.size(), 0);
        pix_ready = 1'b1;
        wait_done("frameC");
        check_frame("frameC");
        chk("frameC_rr_first", emit_q[0], 0);
        chk("frameC_rr_second", emit_q[1], 1);

        // Frame D: coordinate wrap, and a start pulse mid-frame that must be ignored
        start_frame(32'h7FFF_FFFF, 32'h0000_1000, 32'h0000_0001, 32'h0000_0010);
        repeat (3) @(posedge clk);
        #1;
        x_start = 32'h0; dx = 32'h5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("frameD");
        check_frame("frameD");
        chk("frameD_wrap_col1", load_x[1], 32'h8000_0000);
        chk("frameD_row1_x", load_x[4], 32'h7FFF_FFFF);
        chk("frameD_row1_y", load_y[4], 32'h0000_1010);

        // Frame E: reset mid-frame, then a clean full frame
        start_frame(32'h0400_0000, 32'h0, 32'h0000_1000, 32'h0010_0000);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_no_done_yet", fd_cnt, 0);
        rst = 1'b1;
        #1;
        chk("abort_w_enable", w_enable, 0);
        chk("abort_pix_valid", pix_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_no_frame_done", fd_cnt, 0);
        start_frame(32'hC000_0000, 32'h4000_0000, 32'h0800_0000, 32'hF800_0000);
        wait_done("frameE");
        check_frame("frameE");
        chk("frameE_first_load", load_x[0], 32'hC000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
